// File: rtl/acu_fetch_seq_pkg.sv
// Shared types for the acu operand fetch sequencer: addressing modes and FSM states.
package acu_fetch_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ABS   = 2'b00,
        MODE_ZP    = 2'b01,
        MODE_ABS_X = 2'b10,
        MODE_ZP_X  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_WRITE_LO = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_WRITE_HI = 3'd4,
        ST_PRESENT  = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Bit 1 of the mode selects indexing, bit 0 selects the one-byte zero-page form.
    function automatic logic mode_indexed(input mode_e m);
        return m[1];
    endfunction

    function automatic logic mode_two_byte(input mode_e m);
        return ~m[0];
    endfunction

endpackage

// File: rtl/acu_fetch_seq_if.sv
// Byte-wide program memory read bus: the sequencer is master, memory is slave.
interface acu_fetch_seq_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/acu_fetch_seq_ack_timer.sv
// Generic wait-for-acknowledge watchdog: counts enabled cycles and flags the last allowed one.
module acu_fetch_seq_ack_timer #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned TO_W  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = (LIMIT == 32'd0) ? '0 : TO_W'(LIMIT - 32'd1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // LIMIT of zero disables expiry entirely.
    assign expire_o = (LIMIT != 32'd0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/acu_fetch_seq.sv
// Fetches a 1/2-byte address operand, optionally indexes it, and loads it into the acu.
module acu_fetch_seq
    import acu_fetch_seq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic [7:0]             idx_i,
    input  logic [15:0]            pc_in_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [15:0]            pc_out_o,
    output logic [7:0]             acu_d_o,
    output logic                   acu_wl_o,
    output logic                   acu_wh_o,
    output logic                   acu_oe_o,
    acu_fetch_seq_if.master        mem
);

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        carry_q, carry_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  acu_d_q, acu_d_d;
    logic        wl_q, wl_d;
    logic        wh_q, wh_d;
    logic        oe_q, oe_d;

    logic        in_fetch_s;
    logic        ack_s;
    logic        expire_s;
    logic [8:0]  sum_s;

    assign in_fetch_s = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);
    assign ack_s      = in_fetch_s && mem.mem_ack;
    assign sum_s      = {1'b0, mem.mem_rdata} + {1'b0, (mode_indexed(mode_q) ? idx_q : 8'h00)};

    acu_fetch_seq_ack_timer #(
        .LIMIT (ACK_TIMEOUT),
        .TO_W  (TO_W)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (~in_fetch_s | mem.mem_ack),
        .en_i     (in_fetch_s & ~mem.mem_ack),
        .expire_o (expire_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_e'(mode_i);
                    idx_d   = idx_i;
                    ptr_d   = pc_in_i;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    carry_d = 1'b0;
                    state_d = ST_FETCH_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH_LO: begin
                if (ack_s) begin
                    lo_d    = sum_s[7:0];
                    carry_d = sum_s[8];
                    ptr_d   = ptr_q + 16'd1;
                    state_d = ST_WRITE_LO;
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH_LO;
                end
            end
            ST_WRITE_LO: begin
                // Zero-page forms drop the carry and present a zero high byte.
                if (mode_two_byte(mode_q)) begin
                    state_d = ST_FETCH_HI;
                end else begin
                    hi_d    = 8'h00;
                    state_d = ST_WRITE_HI;
                end
            end
            ST_FETCH_HI: begin
                if (ack_s) begin
                    hi_d    = mem.mem_rdata + {7'd0, carry_q};
                    ptr_d   = ptr_q + 16'd1;
                    state_d = ST_WRITE_HI;
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH_HI;
                end
            end
            ST_WRITE_HI: state_d = ST_PRESENT;
            ST_PRESENT:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_FETCH_LO) || (state_d == ST_FETCH_HI);
        addr_d = req_d ? ptr_d : 16'h0000;
        wl_d   = (state_d == ST_WRITE_LO);
        wh_d   = (state_d == ST_WRITE_HI);
        oe_d   = (state_d == ST_PRESENT) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);

        case (state_d)
            ST_WRITE_LO: acu_d_d = lo_d;
            ST_WRITE_HI: acu_d_d = hi_d;
            default:     acu_d_d = 8'h00;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ABS;
            idx_q   <= 8'h00;
            ptr_q   <= 16'h0000;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= 16'h0000;
            acu_d_q <= 8'h00;
            wl_q    <= 1'b0;
            wh_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            acu_d_q <= acu_d_d;
            wl_q    <= wl_d;
            wh_q    <= wh_d;
            oe_q    <= oe_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign pc_out_o     = ptr_q;
    assign acu_d_o      = acu_d_q;
    assign acu_wl_o     = wl_q;
    assign acu_wh_o     = wh_q;
    assign acu_oe_o     = oe_q;
    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

endmodule

// File: doc/acu_fetch_seq.md
Name: acu_fetch_seq

Overview:
Upstream sequencer for the 16-bit address capture unit (acu). On a start request it fetches a 1- or 2-byte address operand from program memory over a req/ack byte interface and optionally adds an 8-bit index. It writes the result into the acu low byte (wl) and then the high byte (wh), and asserts the acu output enable so the address is driven onto the address bus. It also returns the advanced fetch pointer to the program counter.

Parameters:
ACK_TIMEOUT, 16, max wait cycles per memory fetch before abort; 0 = wait forever
TO_W, 5, width of the timeout counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin operand fetch; sampled only in IDLE
mode  in  2  00 ABS, 01 ZP, 10 ABS_X, 11 ZP_X; latched at start
idx  in  8  index value; latched at start
pc_in  in  16  address of first operand byte; latched at start
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse, address valid on acu q
err  out  1  one-cycle pulse on fetch timeout
pc_out  out  16  fetch pointer (next unread byte address)
mem_req  out  1  byte read request
mem_addr  out  16  read address, stable while mem_req high
mem_ack  in  1  read data valid this cycle
mem_rdata  in  8  read data
acu_d  out  8  byte to acu d
acu_wl  out  1  acu low-byte write
acu_wh  out  1  acu high-byte write
acu_oe  out  1  acu output enable

Behaviour:
- Reset (clk, rst synchronous active-high): state IDLE; all outputs 0, including pc_out, acu_d and mem_addr; timeout counter cleared. Reset mid-operation abandons the fetch immediately with no further acu writes. acu shares rst, so its register clears too.
- States: IDLE, FETCH_LO, WRITE_LO, FETCH_HI, WRITE_HI, PRESENT, DONE. All outputs are registered and decoded from state.
- IDLE: start=1 latches mode, idx and ptr<=pc_in, then goes to FETCH_LO. start while busy is ignored.
- FETCH_LO/FETCH_HI:
  - mem_req=1 and mem_addr=ptr.
  - On a cycle with mem_ack=1: capture mem_rdata, ptr<=ptr+1 (16-bit wrap FFFF->0000), clear the timeout counter, and advance.
  - mem_ack outside FETCH states is ignored.
- Arithmetic:
  - lo = rdata + (indexed ? idx : 0). The 9-bit sum gives carry c.
  - ABS_X: hi = rdata_hi + c, 8-bit wrap.
  - ZP_X: the carry is dropped and hi = 00.
  - ZP and ZP_X never enter FETCH_HI.
- WRITE_LO: acu_d=lo, acu_wl=1 for exactly one cycle. Next state is FETCH_HI (ABS, ABS_X) or WRITE_HI with hi=00 (ZP, ZP_X).
- WRITE_HI: acu_d=hi, acu_wh=1 for exactly one cycle. wl and wh are never high together.
- PRESENT: acu_oe=1 so the acu loads q at the next edge.
- DONE: acu_oe=1, done=1 for one cycle, then IDLE. In IDLE acu_oe=0 and the acu tristates.
- pc_out always equals ptr. Final value is pc_in+2 (ABS modes) or pc_in+1 (ZP modes).
- Timeout: in a FETCH state without ack, the counter increments. On reaching ACK_TIMEOUT, the block drops mem_req, pulses err for one cycle and returns to IDLE. Any acu byte already written stands. done is not asserted.
- Latency with zero-wait memory (start sampled at edge 0): ABS/ABS_X done in cycle 6, ZP/ZP_X in cycle 5. Each ack wait cycle adds 1.

Decomposition:
- Shared package: mode encodings (MODE_ABS, MODE_ZP, MODE_ABS_X, MODE_ZP_X) and the state enum/constants.
- Sub-module: ack_timer (TO_W counter with clear/enable/expire), reusable by other bus masters. The rest stays flat.

Test Plan:
- ABS, pc_in=0x1000, memory 1000:34 1001:12, zero wait -> wl with d=34, then wh with d=12; done in cycle 6; acu q=0x1234; pc_out=0x1002.
- ABS_X, bytes F0 12, idx=0x20 -> lo=10 with carry; hi=13; q=0x1310; total cycles identical to ABS.
- ZP_X, byte F0, idx=0x20 -> lo=10, hi=00, q=0x0010; single memory request; pc_out=pc_in+1; done in cycle 5.
- ABS with 3-cycle ack delay on each byte -> mem_addr stable during each wait; done in cycle 12; start pulses while busy are ignored.
- ACK_TIMEOUT=4, no ack on the high byte -> err pulse 4 cycles into FETCH_HI; no wh; no done; back to IDLE with acu_oe=0.
- rst asserted in WRITE_HI -> next cycle all outputs 0, state IDLE, acu q tristated; a new start then completes normally.
